// File: rtl/bw_io_impctl_pkg.sv
// Shared types and constants for the impedance-control clock/strobe generator.
//  ch_state_t : per-channel update sequencer states
//  GRST_TICKS : sclk ticks counted after reset release before global_reset_n rises
package bw_io_impctl_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_OE   = 2'd1,
      CH_UPD  = 2'd2
   } ch_state_t;

   localparam int unsigned GRST_TICKS = 4;

endpackage

// File: rtl/bw_io_impctl_chfsm.sv
// One impedance-update channel: rising-edge detect on the request, a 1-deep pending
// flag and the IDLE -> OE -> UPD sequencer that frames each update.
// Ports:
//  clk_i        core clock
//  reset_i      async active-high reset
//  tick_i       one-cycle sclk tick from the divider
//  grst_n_i     sequencing is allowed only once this is high
//  bypass_i     registered bypass; forces idle and strobes directly on request edges
//  upd_req_i    update request, already synchronous to clk_i
//  oe_o         output-enable window
//  updclk_en_o  one-cycle update strobe
module bw_io_impctl_chfsm
   import bw_io_impctl_pkg::*;
#(
   parameter int unsigned OE_TICKS = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic tick_i,
   input  logic grst_n_i,
   input  logic bypass_i,
   input  logic upd_req_i,
   output logic oe_o,
   output logic updclk_en_o
);

   localparam int unsigned CntW = (OE_TICKS > 1) ? $clog2(OE_TICKS) : 1;

   logic            req_q;
   logic            edge_q;
   logic            pend_q, pend_d;
   ch_state_t       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            oe_q, oe_d;
   logic            upd_q, upd_d;
   logic            serve;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      oe_d    = oe_q;
      upd_d   = 1'b0;
      pend_d  = pend_q;
      serve   = 1'b0;
      if (bypass_i) begin
         // Any sequence in flight is dropped without a strobe.
         state_d = CH_IDLE;
         cnt_d   = '0;
         oe_d    = 1'b0;
         pend_d  = 1'b0;
         upd_d   = edge_q;
      end else begin
         if (tick_i && grst_n_i) begin
            unique case (state_q)
               CH_IDLE: begin
                  if (pend_q) begin
                     state_d = CH_OE;
                     cnt_d   = '0;
                     oe_d    = 1'b1;
                     serve   = 1'b1;
                  end
               end
               CH_OE: begin
                  if (cnt_q == CntW'(OE_TICKS - 1)) begin
                     state_d = CH_UPD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               CH_UPD: begin
                  state_d = CH_IDLE;
                  oe_d    = 1'b0;
                  upd_d   = 1'b1;
               end
               default: begin
                  state_d = CH_IDLE;
                  oe_d    = 1'b0;
               end
            endcase
         end
         // A fresh edge wins over the clear so a request landing on the serving
         // tick is not lost.
         if (edge_q) begin
            pend_d = 1'b1;
         end else if (serve) begin
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         req_q   <= 1'b0;
         edge_q  <= 1'b0;
         pend_q  <= 1'b0;
         state_q <= CH_IDLE;
         cnt_q   <= '0;
         oe_q    <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         req_q   <= upd_req_i;
         edge_q  <= upd_req_i & ~req_q;
         pend_q  <= pend_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oe_q    <= oe_d;
         upd_q   <= upd_d;
      end
   end

   assign oe_o        = oe_q;
   assign updclk_en_o = upd_q;

endmodule

// File: rtl/bw_io_impctl_clkgen_mc.sv
// Multi-channel clock/strobe generator for the impedance-control block.
// Divides clk_i into sclk/sclk_tick, stretches the reset release into global_reset_n,
// emits the periodic averaging-counter reset and sequences per-channel updates.
// Ports:
//  clk_i             core clock
//  reset_i           async active-high reset
//  div_ratio_i       divide ratio R; tick period R+1 clocks, sampled at reload only
//  upd_req_i         per-channel update requests (clk_i synchronous)
//  bypass_mode_i     1 = skip sequencing, strobe directly on request edges
//  sclk_o            divided clock, period 2*(R+1)
//  sclk_tick_o       one-cycle pulse per sclk half-period
//  oe_out_o          per-channel output-enable window
//  updclk_en_o       per-channel one-cycle update strobe
//  bypass_o          bypass_mode_i delayed one clock
//  global_reset_n_o  low until GRST_TICKS ticks after reset release
//  avgcntr_rst_o     one-cycle averaging-counter reset
module bw_io_impctl_clkgen_mc
   import bw_io_impctl_pkg::*;
#(
   parameter int unsigned NCH       = 2,
   parameter int unsigned DIV_W     = 4,
   parameter int unsigned OE_TICKS  = 2,
   parameter int unsigned AVG_TICKS = 64
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [DIV_W-1:0] div_ratio_i,
   input  logic [NCH-1:0]   upd_req_i,
   input  logic             bypass_mode_i,
   output logic             sclk_o,
   output logic             sclk_tick_o,
   output logic [NCH-1:0]   oe_out_o,
   output logic [NCH-1:0]   updclk_en_o,
   output logic             bypass_o,
   output logic             global_reset_n_o,
   output logic             avgcntr_rst_o
);

   localparam int unsigned GrstW = (GRST_TICKS > 1) ? $clog2(GRST_TICKS) : 1;
   localparam int unsigned AvgW  = $clog2(AVG_TICKS);

   logic             live_q;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sclk_q, sclk_d;
   logic             bypass_q;
   logic [GrstW-1:0] grst_cnt_q, grst_cnt_d;
   logic             grst_n_q, grst_n_d;
   logic [AvgW-1:0]  avg_cnt_q, avg_cnt_d;
   logic             avg_q, avg_d;
   logic             tick;

   // live_q keeps the tick quiet while reset is held even though the counter sits at 0;
   // the first tick comes one clock after release.
   assign tick = live_q & (div_cnt_q == '0);

   always_comb begin
      div_cnt_d = div_cnt_q;
      sclk_d    = sclk_q;
      if (tick) begin
         div_cnt_d = div_ratio_i;
         sclk_d    = ~sclk_q;
      end else if (live_q) begin
         div_cnt_d = div_cnt_q - 1'b1;
      end
   end

   always_comb begin
      grst_cnt_d = grst_cnt_q;
      grst_n_d   = grst_n_q;
      avg_cnt_d  = avg_cnt_q;
      avg_d      = 1'b0;
      if (tick) begin
         if (!grst_n_q) begin
            if (grst_cnt_q == GrstW'(GRST_TICKS - 1)) begin
               grst_n_d  = 1'b1;
               avg_d     = 1'b1;
               avg_cnt_d = '0;
            end else begin
               grst_cnt_d = grst_cnt_q + 1'b1;
            end
         end else if (avg_cnt_q == AvgW'(AVG_TICKS - 1)) begin
            avg_cnt_d = '0;
            avg_d     = 1'b1;
         end else begin
            avg_cnt_d = avg_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         live_q     <= 1'b0;
         div_cnt_q  <= '0;
         sclk_q     <= 1'b0;
         bypass_q   <= 1'b0;
         grst_cnt_q <= '0;
         grst_n_q   <= 1'b0;
         avg_cnt_q  <= '0;
         avg_q      <= 1'b0;
      end else begin
         live_q     <= 1'b1;
         div_cnt_q  <= div_cnt_d;
         sclk_q     <= sclk_d;
         bypass_q   <= bypass_mode_i;
         grst_cnt_q <= grst_cnt_d;
         grst_n_q   <= grst_n_d;
         avg_cnt_q  <= avg_cnt_d;
         avg_q      <= avg_d;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      bw_io_impctl_chfsm #(
         .OE_TICKS(OE_TICKS)
      ) u_chfsm (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .tick_i      (tick),
         .grst_n_i    (grst_n_q),
         .bypass_i    (bypass_q),
         .upd_req_i   (upd_req_i[g]),
         .oe_o        (oe_out_o[g]),
         .updclk_en_o (updclk_en_o[g])
      );
   end

   assign sclk_o           = sclk_q;
   assign sclk_tick_o      = tick;
   assign bypass_o         = bypass_q;
   assign global_reset_n_o = grst_n_q;
   assign avgcntr_rst_o    = avg_q;

endmodule

// File: tb/tb_bw_io_impctl_clkgen_mc.sv
module tb_bw_io_impctl_clkgen_mc;

   localparam int NCH = 2;
   localparam int OE  = 2;
   localparam int AVG = 6;

   logic           clk;
   logic           reset;
   logic [3:0]     div_ratio;
   logic [NCH-1:0] upd_req;
   logic           bypass_mode;
   logic           sclk, sclk_tick, bypass, global_reset_n, avgcntr_rst;
   logic [NCH-1:0] oe_out, updclk_en;

   int checks = 0;
   int errors = 0;

   bw_io_impctl_clkgen_mc #(
      .NCH(NCH), .DIV_W(4), .OE_TICKS(OE), .AVG_TICKS(AVG)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .div_ratio_i      (div_ratio),
      .upd_req_i        (upd_req),
      .bypass_mode_i    (bypass_mode),
      .sclk_o           (sclk),
      .sclk_tick_o      (sclk_tick),
      .oe_out_o         (oe_out),
      .updclk_en_o      (updclk_en),
      .bypass_o         (bypass),
      .global_reset_n_o (global_reset_n),
      .avgcntr_rst_o    (avgcntr_rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: absolute cycle numbers for ticks, tick tallies for the reset
   // stretch and averaging period, and a per-channel "ticks until strobe" countdown.
   int       cyc, m_next, m_seen, m_after;
   bit       m_live, m_sclk, m_byp, m_grst, m_avg;
   bit [1:0] m_prev, m_edge, m_pend, m_upd;
   int       m_left [NCH];
   int       cnt0, cnt1;

   function automatic void model_reset();
      cyc = 0; m_next = 1; m_seen = 0; m_after = 0;
      m_live = 0; m_sclk = 0; m_byp = 0; m_grst = 0; m_avg = 0;
      m_prev = 0; m_edge = 0; m_pend = 0; m_upd = 0;
      for (int i = 0; i < NCH; i++) m_left[i] = 0;
   endfunction

   function automatic void model_clock();
      bit t, byp_old, grst_old, e_old, served;
      t        = m_live && (cyc == m_next);
      byp_old  = m_byp;
      grst_old = m_grst;
      m_byp    = bypass_mode;
      if (t) begin
         m_next = cyc + int'(div_ratio) + 1;
         m_sclk = !m_sclk;
      end
      m_live = 1;
      m_avg  = 0;
      if (t) begin
         if (!grst_old) begin
            m_seen++;
            if (m_seen == 4) begin m_grst = 1; m_avg = 1; end
         end else begin
            m_after++;
            if (m_after % AVG == 0) m_avg = 1;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         e_old     = m_edge[i];
         m_edge[i] = upd_req[i] & ~m_prev[i];
         m_prev[i] = upd_req[i];
         m_upd[i]  = 0;
         served    = 0;
         if (byp_old) begin
            m_left[i] = 0;
            m_pend[i] = 0;
            m_upd[i]  = e_old;
         end else begin
            if (t && grst_old) begin
               if (m_left[i] > 0) begin
                  m_left[i]--;
                  if (m_left[i] == 0) m_upd[i] = 1;
               end else if (m_pend[i]) begin
                  m_left[i] = OE + 1;
                  served    = 1;
               end
            end
            if (e_old) m_pend[i] = 1;
            else if (served) m_pend[i] = 0;
         end
      end
      cyc++;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("sclk_tick", 32'(sclk_tick), 32'(m_live && (cyc == m_next)));
      chk("sclk", 32'(sclk), 32'(m_sclk));
      chk("oe_out", 32'(oe_out), {30'b0, m_left[1] > 0, m_left[0] > 0});
      chk("updclk_en", 32'(updclk_en), 32'(m_upd));
      chk("bypass", 32'(bypass), 32'(m_byp));
      chk("global_reset_n", 32'(global_reset_n), 32'(m_grst));
      chk("avgcntr_rst", 32'(avgcntr_rst), 32'(m_avg));
   endtask

   // One clock: advance the model on the edge, compare on the falling edge.
   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else model_clock();
      @(negedge clk);
      check_all();
      cnt0 += int'(updclk_en[0]);
      cnt1 += int'(updclk_en[1]);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse(input int ch);
      upd_req[ch] = 1'b1;
      step();
      upd_req[ch] = 1'b0;
      step();
   endtask

   task automatic wait_grst(input string tag);
      int n;
      n = 0;
      while (global_reset_n !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk(tag, 32'(n), 32'd14);
      chk({tag, "_avg"}, 32'(avgcntr_rst), 32'd1);
   endtask

   initial begin
      int n;
      reset       = 1'b1;
      div_ratio   = 4'd3;
      upd_req     = '0;
      bypass_mode = 1'b0;
      model_reset();
      cnt0 = 0;
      cnt1 = 0;
      run(3);

      // 1: R=3 reset stretch, global_reset_n and avgcntr_rst after the 4th tick
      reset = 1'b0;
      wait_grst("grst_cycles");
      run(30);

      // 2: single request on channel 0
      cnt0 = 0; cnt1 = 0;
      pulse(0);
      run(30);
      chk("ch0_single_strobes", 32'(cnt0), 32'd1);
      chk("ch1_quiet", 32'(cnt1), 32'd0);

      // 3: extra edges during CH_OE merge into one further update
      cnt0 = 0; cnt1 = 0;
      pulse(1);
      n = 0;
      while (oe_out[1] !== 1'b1 && n < 20) begin step(); n++; end
      chk("ch1_oe_timeout", 32'(n < 20), 32'd1);
      for (int k = 0; k < 3; k++) pulse(1);
      run(60);
      chk("ch1_merged_strobes", 32'(cnt1), 32'd2);

      // 4: R 3->0 mid-period
      n = 0;
      while (sclk_tick !== 1'b1 && n < 20) begin step(); n++; end
      chk("tick_timeout", 32'(n < 20), 32'd1);
      step();
      div_ratio = 4'd0;
      n = 1;
      while (sclk_tick !== 1'b1 && n < 20) begin step(); n++; end
      chk("ratio_change_period", 32'(n), 32'd4);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("r0_tick", 32'(sclk_tick), 32'd1);
      end
      div_ratio = 4'd2;
      run(10);

      // 5: bypass strobes directly, no oe window
      bypass_mode = 1'b1;
      step();
      chk("bypass_delay", 32'(bypass), 32'd1);
      upd_req[0] = 1'b1;
      step();
      step();
      chk("bypass_strobe", 32'(updclk_en[0]), 32'd1);
      chk("bypass_oe", 32'(oe_out[0]), 32'd0);
      upd_req[0] = 1'b0;
      run(5);
      bypass_mode = 1'b0;
      run(5);

      // Abort an in-flight sequence by toggling bypass
      cnt0 = 0;
      pulse(0);
      n = 0;
      while (oe_out[0] !== 1'b1 && n < 20) begin step(); n++; end
      bypass_mode = 1'b1;
      run(3);
      bypass_mode = 1'b0;
      run(30);
      chk("abort_no_strobe", 32'(cnt0), 32'd0);

      // Randomised traffic against the model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 7) == 0) upd_req[0] = ~upd_req[0];
         if ($urandom_range(0, 7) == 0) upd_req[1] = ~upd_req[1];
         if ($urandom_range(0, 95) == 0) bypass_mode = ~bypass_mode;
         if ($urandom_range(0, 31) == 0) div_ratio = 4'($urandom_range(0, 4));
         step();
      end
      bypass_mode = 1'b0;
      upd_req     = '0;
      div_ratio   = 4'd3;
      run(40);

      // 6: reset during CH_OE
      pulse(0);
      n = 0;
      while (oe_out[0] !== 1'b1 && n < 40) begin step(); n++; end
      chk("pre_reset_oe", 32'(oe_out[0]), 32'd1);
      reset = 1'b1;
      model_reset();
      #1;
      chk("reset_oe", 32'(oe_out), 32'd0);
      chk("reset_sclk", 32'(sclk), 32'd0);
      chk("reset_grst", 32'(global_reset_n), 32'd0);
      run(2);
      reset = 1'b0;
      wait_grst("grst_cycles_again");
      run(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
